// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, the instruction memory and the decode stage.
// master = fetch_queue side, slave = memory/decode environment side.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  rom_ce;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_ready;
  logic                  rom_valid;
  logic [INST_WIDTH-1:0] rom_data;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic                  id_stall;
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [INST_WIDTH-1:0] id_instruction;
  logic [CNT_WIDTH-1:0]  count;

  modport master (
    output rom_ce, rom_address, id_valid, id_pc, id_instruction, count,
    input  rom_ready, rom_valid, rom_data, redirect, redirect_pc, id_stall
  );

  modport slave (
    input  rom_ce, rom_address, id_valid, id_pc, id_instruction, count,
    output rom_ready, rom_valid, rom_data, redirect, redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding memory request, DEPTH-entry {pc, inst} FIFO to ID.
// Redirect flushes the FIFO and restarts fetch; an in-flight response is dropped.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]         C_DEPTH = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_STEP  = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rom_ce;
  logic [ADDR_WIDTH-1:0] r_rom_address;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [INST_WIDTH-1:0] r_mem_inst [DEPTH];

  logic w_id_valid;
  logic w_push;
  logic w_pop;
  logic w_space;

  // Redirect wins over both FIFO ports: nothing enters or leaves on a flush cycle.
  assign w_id_valid = (r_count != '0);
  assign w_pop      = w_id_valid && !bus.id_stall && !bus.redirect;
  assign w_push     = (r_state == S_WAIT) && bus.rom_valid && !bus.redirect;

  always_comb begin
    w_count_next = r_count;
    if (bus.redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  assign w_space = (w_count_next < C_DEPTH);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    if (bus.redirect) begin
      w_fetch_pc_next = bus.redirect_pc;
      case (r_state)
        S_IDLE:  w_state_next = S_REQ;
        S_REQ:   w_state_next = bus.rom_ready ? S_DROP : S_REQ;
        S_WAIT:  w_state_next = bus.rom_valid ? S_REQ : S_DROP;
        S_DROP:  w_state_next = bus.rom_valid ? S_REQ : S_DROP;
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_space) w_state_next = S_REQ;
        end
        S_REQ: begin
          if (bus.rom_ready) w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (bus.rom_valid) begin
            w_fetch_pc_next = r_fetch_pc + C_STEP;
            w_state_next    = w_space ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.rom_valid) w_state_next = S_REQ;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // The request address tracks fetch_pc, which only moves on a push or a redirect,
  // so it stays stable for as long as a request sits unaccepted in REQ.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rom_ce      <= 1'b0;
      r_rom_address <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rom_ce      <= (w_state_next == S_REQ);
      r_rom_address <= w_fetch_pc_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_count       <= w_count_next;
      if (bus.redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_fetch_pc;
      r_mem_inst[r_wptr] <= bus.rom_data;
    end
  end

  assign bus.rom_ce         = r_rom_ce;
  assign bus.rom_address    = r_rom_address;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_pc          = w_id_valid ? r_mem_pc[r_rptr]   : '0;
  assign bus.id_instruction = w_id_valid ? r_mem_inst[r_rptr] : '0;
  assign bus.count          = r_count;

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    r_count <= C_DEPTH);

  a_ce_matches_req: assert property (@(posedge clock) disable iff (reset)
    r_rom_ce == (r_state == S_REQ));

  a_addr_held: assert property (@(posedge clock) disable iff (reset)
    (r_rom_ce && !bus.rom_ready && !bus.redirect) |=> $stable(r_rom_address));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-bench instruction memory (data = address ^ 0xDEAD0000).
module tb_fetch_queue;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) bus ();

  fetch_queue #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0),
    .PC_STEP   (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  bit          mem_on;
  int          mem_lat;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // One clock: sample the request at the edge, then update the memory response 1ns later.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    @(posedge clock);
    acc = mem_on && bus.rom_ce && bus.rom_ready;
    a   = bus.rom_address;
    #1;
    bus.rom_valid = 1'b0;
    bus.rom_data  = '0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_wait = mem_lat - 1;
    end else if (pend && pend_wait > 0) begin
      pend_wait--;
    end
    if (pend && pend_wait == 0) begin
      bus.rom_valid = 1'b1;
      bus.rom_data  = inst_of(pend_addr);
      pend          = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_stall    = 1'b0;
    bus.rom_ready   = 1'b1;
    step();
    step();
    reset         = 1'b0;
    pend          = 1'b0;
    bus.rom_valid = 1'b0;
    bus.rom_data  = '0;
    mem_on        = 1'b1;
    mem_lat       = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          ce_hi;
    logic [31:0] exp_pc;

    reset           = 1'b1;
    bus.rom_ready   = 1'b1;
    bus.rom_valid   = 1'b0;
    bus.rom_data    = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_stall    = 1'b0;
    mem_on          = 1'b1;
    mem_lat         = 1;
    pend            = 1'b0;
    pend_addr       = '0;
    pend_wait       = 0;

    do_reset();
    check("rst_ce",    bus.rom_ce, 0);
    check("rst_addr",  bus.rom_address, 0);
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.id_valid, 0);
    check("rst_pc",    bus.id_pc, 0);
    check("rst_inst",  bus.id_instruction, 0);

    // Zero-wait memory, no stall: 0,4,8,C at one per two cycles.
    step();
    check("t1_ce_e0",    bus.rom_ce, 1);
    check("t1_valid_e0", bus.id_valid, 0);
    step();
    check("t1_ce_e1",    bus.rom_ce, 0);
    check("t1_valid_e1", bus.id_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", bus.id_valid, 1);
      check("t1_pc",    bus.id_pc, 32'(4 * k));
      check("t1_inst",  bus.id_instruction, inst_of(32'(4 * k)));
      check("t1_ce_hi", bus.rom_ce, 1);
      check("t1_count", bus.count, 1);
      step();
      check("t1_empty", bus.id_valid, 0);
      check("t1_ce_lo", bus.rom_ce, 0);
    end

    // Stall fills the FIFO to DEPTH and fetching stops; release drains in order.
    bus.id_stall = 1'b1;
    ce_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 10 && bus.rom_ce) ce_hi++;
    end
    check("t2_count_full", bus.count, 4);
    check("t2_ce_idle",    ce_hi, 0);
    check("t2_head",       bus.id_pc, 32'h10);
    bus.id_stall = 1'b0;
    exp_pc = 32'h10;
    for (int i = 0; i < 16; i++) begin
      if (bus.id_valid) begin
        check("t2_order", bus.id_pc, exp_pc);
        check("t2_inst",  bus.id_instruction, inst_of(exp_pc));
        exp_pc += 32'd4;
      end
      step();
    end
    check("t2_progress", exp_pc, 32'h3C);

    // Memory not ready: request and address held, nothing pushed.
    do_reset();
    bus.id_stall = 1'b1;
    step();
    step();
    bus.rom_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_ce_held",   bus.rom_ce, 1);
      check("t3_addr_held", bus.rom_address, 32'h4);
      check("t3_no_push",   bus.count, 1);
    end
    bus.rom_ready = 1'b1;
    step();
    check("t3_accepted", bus.rom_ce, 0);
    step();
    check("t3_count2", bus.count, 2);
    check("t3_head0",  bus.id_pc, 0);
    bus.id_stall = 1'b0;
    step();
    check("t3_head4",  bus.id_pc, 32'h4);
    check("t3_count1", bus.count, 1);

    // Redirect in WAIT; the late response is dropped and fetch resumes at 0x100.
    do_reset();
    mem_lat = 3;
    step();
    step();
    check("t4_wait_ce", bus.rom_ce, 0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    check("t4_drop_ce",   bus.rom_ce, 0);
    check("t4_drop_addr", bus.rom_address, 32'h100);
    check("t4_drop_cnt",  bus.count, 0);
    step();
    check("t4_still_drop", bus.rom_ce, 0);
    step();
    check("t4_req_ce",   bus.rom_ce, 1);
    check("t4_req_addr", bus.rom_address, 32'h100);
    check("t4_dropped",  bus.count, 0);
    check("t4_no_valid", bus.id_valid, 0);
    mem_lat = 1;
    step();
    step();
    check("t4_valid", bus.id_valid, 1);
    check("t4_pc",    bus.id_pc, 32'h100);
    check("t4_inst",  bus.id_instruction, 32'hDEAD0100);

    // Redirect together with rom_valid and a pop, FIFO holding three entries.
    do_reset();
    bus.id_stall = 1'b1;
    repeat (8) step();
    check("t5_pre_count", bus.count, 3);
    check("t5_pre_valid", bus.rom_valid, 1);
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    check("t5_count", bus.count, 0);
    check("t5_valid", bus.id_valid, 0);
    check("t5_pc0",   bus.id_pc, 0);
    check("t5_inst0", bus.id_instruction, 0);
    check("t5_ce",    bus.rom_ce, 1);
    check("t5_addr",  bus.rom_address, 32'h200);
    step();
    step();
    check("t5_first_pc",  bus.id_pc, 32'h200);
    check("t5_first_cnt", bus.count, 1);

    // Reset while WAIT; a stale response right after reset must be ignored.
    do_reset();
    mem_on = 1'b0;
    step();
    step();
    check("t6_wait_ce", bus.rom_ce, 0);
    reset = 1'b1;
    step();
    reset         = 1'b0;
    bus.rom_valid = 1'b1;
    bus.rom_data  = 32'hBAD0_BAD0;
    step();
    check("t6_stale_cnt",   bus.count, 0);
    check("t6_stale_valid", bus.id_valid, 0);
    check("t6_req_ce",      bus.rom_ce, 1);
    check("t6_req_addr",    bus.rom_address, 0);
    mem_on = 1'b1;
    pend   = 1'b0;
    step();
    step();
    check("t6_pc",    bus.id_pc, 0);
    check("t6_inst",  bus.id_instruction, 32'hDEAD0000);
    check("t6_count", bus.count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
